shifter_collector: RTL

//  Serial-to-parallel collector for the sum-and-shift multiplier datapath.

---
 rtl/shifter_collector_if.sv | 39 +++
 rtl/shifter_collector.sv | 98 +++++++++
 2 files changed

// File: rtl/shifter_collector_if.sv
// Handshake bundle for the 2-bit serial-to-parallel collector.
// The master side streams digits in and consumes finished words.
interface shifter_collector_if #(
    parameter int tamano = 8
);
    localparam int N  = tamano / 2;
    localparam int CW = $clog2(N) + 1;

    logic              start;
    logic              serial_valid;
    logic [1:0]        serial_data_in;
    logic              out_ready;
    logic [tamano-1:0] parallel_data_out;
    logic              out_valid;
    logic              busy;
    logic [CW-1:0]     digit_count;

    modport master (
        output start,
        output serial_valid,
        output serial_data_in,
        output out_ready,
        input  parallel_data_out,
        input  out_valid,
        input  busy,
        input  digit_count
    );

    modport slave (
        input  start,
        input  serial_valid,
        input  serial_data_in,
        input  out_ready,
        output parallel_data_out,
        output out_valid,
        output busy,
        output digit_count
    );
endinterface

// File: rtl/shifter_collector.sv
// Serial-to-parallel collector: 2-bit digits, LSB first, into a tamano-bit word.
// Finished words are held on a valid/ready output until consumed.
module shifter_collector #(
    parameter int tamano = 8
) (
    input logic                CLOCK,
    input logic                RESET,
    shifter_collector_if.slave bus
);
    localparam int N  = tamano / 2;
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [tamano-1:0] sh_q, sh_d;
    logic [tamano-1:0] pdo_q, pdo_d;
    logic              out_valid_q, out_valid_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [tamano-1:0] sh_next;

    // New digit enters at the top; after N shifts the first digit sits in [1:0].
    assign sh_next = {bus.serial_data_in, sh_q[tamano-1:2]};

    // Next-state and datapath control for the IDLE/COLLECT/DONE sequence.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        pdo_d       = pdo_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.start) begin
                    // Restart wins over a digit arriving the same cycle.
                    sh_d  = '0;
                    cnt_d = '0;
                end else if (bus.serial_valid) begin
                    sh_d = sh_next;
                    if (cnt_q == LAST_DIGIT) begin
                        pdo_d       = sh_next;
                        out_valid_d = 1'b1;
                        cnt_d       = FULL_COUNT;
                        state_d     = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            pdo_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            pdo_q       <= pdo_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.parallel_data_out = pdo_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.busy              = (state_q == COLLECT);
    assign bus.digit_count       = cnt_q;
endmodule
